// File: rtl/fetch_pkg.sv
// Shared types and instruction field positions for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam int INST_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 21;
    localparam int COND19_MSB = 23;
    localparam int COND19_LSB = 5;
    localparam int IMM26_MSB  = 25;
    localparam int IMM26_LSB  = 0;
    localparam int PC_INC     = 4;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC selection: sequential step or a word-scaled signed
// branch offset taken from the held instruction.
module branch_target_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               UncondBr,
    input  logic               BrTaken,
    output logic [ADDR_W-1:0]  next_pc
);

    localparam int C19_W = COND19_MSB - COND19_LSB + 1;
    localparam int I26_W = IMM26_MSB - IMM26_LSB + 1;

    logic [ADDR_W-1:0] off_cond;
    logic [ADDR_W-1:0] off_imm;

    // Offsets count instructions, so scale by four bytes after sign extension.
    assign off_cond = {{(ADDR_W-C19_W){instr[COND19_MSB]}}, instr[COND19_MSB:COND19_LSB]} << 2;
    assign off_imm  = {{(ADDR_W-I26_W){instr[IMM26_MSB]}}, instr[IMM26_MSB:IMM26_LSB]} << 2;

    wire unused_opcode_bits = ^instr[INSTR_W-1:IMM26_MSB+1];

    always_comb begin
        next_pc = pc + ADDR_W'(PC_INC);
        if (BrTaken) begin
            next_pc = pc + (UncondBr ? off_cond : off_imm);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Owns the PC, fetches from variable-latency instruction memory and holds the
// current instruction for control until it retires.
//
// state | meaning
// IDLE  | one cycle after reset, no request outstanding
// REQ   | request for pc outstanding, waiting for imem_ready
// HOLD  | instruction held for control, retires when stall drops
module instr_fetch_unit #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = fetch_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              BrTaken,
    input  logic              UncondBr,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instr,
    output logic [10:0]       OpCode,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       retire_count
);

    import fetch_pkg::*;

    fetch_state_t      state;
    logic [ADDR_W-1:0] next_pc;

    branch_target_calc #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INST_W)
    ) u_branch_target_calc (
        .pc       (pc),
        .instr    (instr),
        .UncondBr (UncondBr),
        .BrTaken  (BrTaken),
        .next_pc  (next_pc)
    );

    assign imem_addr = pc;
    assign OpCode    = instr[OPCODE_MSB:OPCODE_LSB];

    // imem_req is registered alongside the state so it is high exactly in REQ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instr        <= '0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            retire_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_ready) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc           <= next_pc;
                        instr_valid  <= 1'b0;
                        retire_count <= retire_count + 32'd1;
                        imem_req     <= 1'b1;
                        state        <= REQ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    a_req_only_in_req: assert property (
        @(posedge clk) disable iff (reset) (state != REQ) |-> !imem_req
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit with a transaction-level PC model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        BrTaken = 1'b0;
    logic        UncondBr = 1'b0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic [10:0] OpCode;
    logic        instr_valid;
    logic [63:0] pc;
    logic [31:0] retire_count;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_pc = 64'h0;
    logic [31:0] exp_rc = 32'h0;

    instr_fetch_unit #(
        .ADDR_W   (64),
        .INST_W   (32),
        .RESET_PC (64'h0)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .BrTaken      (BrTaken),
        .UncondBr     (UncondBr),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .OpCode       (OpCode),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Target rule straight from the ISA description: offsets are signed word counts.
    function automatic logic [63:0] model_next(input logic [63:0] cur, input logic [31:0] d,
                                               input logic br, input logic unc);
        longint off;
        if (!br) return cur + 64'd4;
        if (unc) off = longint'($signed(d[23:5]));
        else     off = longint'($signed(d[25:0]));
        return cur + 64'(off * 4);
    endfunction

    // One full instruction: request, optional memory wait, hold with stalls, retire.
    task automatic fetch_one(input logic [31:0] data, input int dly, input int nstall,
                             input logic br, input logic unc);
        int guard = 0;
        while (!imem_req && guard < 10) begin
            tick();
            guard++;
        end
        chk("req_seen", 64'(imem_req), 64'd1);
        chk("req_addr", imem_addr, exp_pc);
        for (int i = 0; i < dly; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            tick();
            chk("wait_req", 64'(imem_req), 64'd1);
            chk("wait_addr", imem_addr, exp_pc);
            chk("wait_valid", 64'(instr_valid), 64'd0);
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        tick();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        chk("cap_valid", 64'(instr_valid), 64'd1);
        chk("cap_instr", 64'(instr), 64'(data));
        chk("cap_opcode", 64'(OpCode), 64'(data >> 21));
        chk("cap_pc", pc, exp_pc);
        chk("cap_req", 64'(imem_req), 64'd0);
        for (int i = 0; i < nstall; i++) begin
            stall = 1'b1;
            BrTaken = 1'($urandom);
            UncondBr = 1'($urandom);
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            tick();
            chk("stall_instr", 64'(instr), 64'(data));
            chk("stall_pc", pc, exp_pc);
            chk("stall_rc", 64'(retire_count), 64'(exp_rc));
            chk("stall_req", 64'(imem_req), 64'd0);
            chk("stall_valid", 64'(instr_valid), 64'd1);
        end
        stall = 1'b0;
        BrTaken = br;
        UncondBr = unc;
        imem_ready = 1'b0;
        tick();
        exp_pc = model_next(exp_pc, data, br, unc);
        exp_rc = exp_rc + 32'd1;
        BrTaken = 1'($urandom);
        UncondBr = 1'($urandom);
        chk("ret_req", 64'(imem_req), 64'd1);
        chk("ret_addr", imem_addr, exp_pc);
        chk("ret_rc", 64'(retire_count), 64'(exp_rc));
        chk("ret_valid", 64'(instr_valid), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_pc", pc, 64'h0);
        chk("rst_instr", 64'(instr), 64'h0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_rc", 64'(retire_count), 64'd0);
        reset = 1'b0;
        tick();

        // Immediate-ready fetch then sequential retire.
        fetch_one(32'h91000421, 0, 0, 1'b0, 1'b0);
        chk("first_opcode", 64'(dut.OpCode), 64'(11'b10010001000));
        chk("first_next", imem_addr, 64'h4);
        chk("first_rc", 64'(retire_count), 64'd1);

        fetch_one($urandom, 3, 0, 1'b0, 1'b0);
        fetch_one($urandom, 0, 5, 1'b0, 1'b0);
        while (exp_pc != 64'h20) fetch_one($urandom, 0, 0, 1'b0, 1'b0);

        fetch_one({6'b000101, 26'h3FFFFFE}, 1, 0, 1'b1, 1'b0);
        chk("b_back", imem_addr, 64'h18);
        while (exp_pc != 64'h40) fetch_one($urandom, 0, 0, 1'b0, 1'b0);

        fetch_one({8'hB4, 19'h00003, 5'd0}, 0, 1, 1'b1, 1'b1);
        chk("cbz_taken", imem_addr, 64'h4C);
        fetch_one({6'b000101, 26'h3FFFFFD}, 2, 0, 1'b1, 1'b0);
        chk("b_to_40", imem_addr, 64'h40);
        fetch_one({8'hB4, 19'h00003, 5'd0}, 0, 0, 1'b0, 1'b1);
        chk("cbz_not_taken", imem_addr, 64'h44);

        // Reset while a request is outstanding, then a late ready pulse.
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc, 64'h0);
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_rc", 64'(retire_count), 64'd0);
        tick();
        reset = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_ready = 1'b0;
        chk("late_req", 64'(imem_req), 64'd1);
        chk("late_addr", imem_addr, 64'h0);
        chk("late_valid", 64'(instr_valid), 64'd0);
        chk("late_instr", 64'(instr), 64'h0);
        exp_pc = 64'h0;
        exp_rc = 32'h0;

        for (int n = 0; n < 40; n++) begin
            fetch_one($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of processorControl; owns the PC, fetches instructions from a variable-latency instruction memory over a req/ready handshake, and presents the current instruction and OpCode field to control.
- Computes next PC from control's BrTaken/UncondBr when the instruction retires.
- Throughput is one instruction per two cycles minimum (req cycle + hold cycle).

Parameters:
ADDR_W, 64, PC and instruction-memory address width
INST_W, 32, instruction width
RESET_PC, 64'h0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
BrTaken  input  1  from control; branch taken for the held instruction
UncondBr  input  1  from control; 1 = CondAddr19 (instr[23:5]), 0 = BrAddr26 (instr[25:0])
stall  input  1  downstream not ready; holds current instruction, blocks retire
imem_req  output  1  instruction memory request
imem_addr  output  ADDR_W  request address, equals pc
imem_ready  input  1  memory returns data this cycle
imem_rdata  input  INST_W  instruction word, valid only when imem_ready=1
instr  output  INST_W  held instruction
OpCode  output  11  instr[31:21], to control
instr_valid  output  1  instr/OpCode hold a fetched instruction
pc  output  ADDR_W  address of the held/in-flight instruction
retire_count  output  32  number of retired instructions

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset); all state clears immediately on assertion, independent of clk.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retire_count=0.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: imem_req=0; next cycle -> REQ. Entered only from reset.
  - REQ: imem_req=1, imem_addr=pc. Addr and req stay stable until imem_ready. On imem_ready=1: instr<=imem_rdata, instr_valid<=1, -> HOLD. Else stay in REQ.
  - HOLD: imem_req=0, instr_valid=1. If stall=1, stay in HOLD with instr and pc unchanged. If stall=0, retire this edge: pc<=next_pc, instr_valid<=0, retire_count<=retire_count+1, -> REQ.
- next_pc:
  - BrTaken=0: pc+4.
  - BrTaken=1, UncondBr=1: pc + (sext64(instr[23:5])<<2).
  - BrTaken=1, UncondBr=0: pc + (sext64(instr[25:0])<<2).
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- BrTaken, UncondBr and stall are sampled only in HOLD. They are ignored in IDLE and REQ.
- imem_rdata is ignored whenever imem_ready=0 or state!=REQ. A stray imem_ready outside REQ has no effect.
- Latency: imem_ready in the REQ cycle puts instr_valid high the next cycle. Retire with stall=0 puts imem_req high for the new pc the cycle after.
- retire_count wraps from 2^32-1 to 0.
- Reset mid-handshake (in REQ with ready pending) abandons the request. Memory must tolerate a dropped req.
- imem_req=1 in IDLE or HOLD is illegal and is an assertion target.

Decomposition:
- fetch_pkg: state enum (IDLE, REQ, HOLD); INST_W; field positions OPCODE_MSB=31/LSB=21, COND19_MSB=23/LSB=5, IMM26_MSB=25/LSB=0; PC_INC=4.
- One sub-module: branch_target_calc. Combinational; inputs pc, instr, UncondBr, BrTaken; output next_pc. Instantiated once inside instr_fetch_unit.

Test Plan:
- Reset, then release; memory returns 32'h91000421 with ready in the same cycle as req -> cycle 1 imem_req=1, addr=0; cycle 2 instr_valid=1, OpCode=11'b10010001000; stall=0 -> next req addr=4, retire_count=1.
- Memory ready delayed 3 cycles -> imem_req and imem_addr stable for all 3 cycles; instr captured only on the ready cycle.
- B imm26=26'h3FFFFFE (-2) held at pc=0x20, BrTaken=1, UncondBr=0 -> next req addr=0x18.
- CBZ cond19=19'h00003 at pc=0x40, UncondBr=1: BrTaken=1 -> next addr 0x4C; repeat with BrTaken=0 -> next addr 0x44.
- stall=1 for 5 cycles in HOLD -> instr, pc and retire_count frozen, imem_req=0; stall drop -> retire on that edge.
- Assert reset while in REQ awaiting ready; late ready pulse after release -> pc=RESET_PC, instr_valid=0, late data ignored, state restarts IDLE->REQ.
